// File: rtl/dram_wd_collector_if.sv
// Bus bundle for the DRAM write-data collector: command channel, ALU
// write-data channel, DRAM write channel and status outputs.
// slave  = collector side, master = environment side (ALU/controller/DRAM).
interface dram_wd_collector_if #(
  parameter int DBW   = 16,
  parameter int VSIZE = 32,
  parameter int GBW   = 32,
  parameter int LBW   = 8
);
  // Write-command channel
  logic                   cmd_rdy;
  logic                   cmd_ack;
  logic [GBW-1:0]         i_cmd_addr;
  logic [LBW-1:0]         i_cmd_len;
  // ALU write-data channel
  logic                   dramwd_rdy;
  logic                   dramwd_ack;
  logic [VSIZE*DBW-1:0]   i_dramwd;
  // DRAM write channel
  logic                   dramw_rdy;
  logic                   dramw_ack;
  logic [GBW-1:0]         o_dramw_addr;
  logic [VSIZE*DBW-1:0]   o_dramw_data;
  logic                   o_dramw_last;
  // Status
  logic                   done_dval;
  logic                   o_busy;

  modport slave (
    input  cmd_rdy, i_cmd_addr, i_cmd_len,
    input  dramwd_rdy, i_dramwd,
    input  dramw_ack,
    output cmd_ack, dramwd_ack,
    output dramw_rdy, o_dramw_addr, o_dramw_data, o_dramw_last,
    output done_dval, o_busy
  );

  modport master (
    output cmd_rdy, i_cmd_addr, i_cmd_len,
    output dramwd_rdy, i_dramwd,
    output dramw_ack,
    input  cmd_ack, dramwd_ack,
    input  dramw_rdy, o_dramw_addr, o_dramw_data, o_dramw_last,
    input  done_dval, o_busy
  );
endinterface

// File: rtl/dram_wd_collector.sv
// DRAM write-data collector. Accepts a burst command (base word address and
// beat count), pairs it with write-data beats coming from the ALU through a
// 2-entry FIFO, and emits addressed DRAM write beats. The FIFO accepts beats
// in any state, so data may be prefetched before the command arrives.
module dram_wd_collector #(
  parameter int DBW   = 16,
  parameter int VSIZE = 32,
  parameter int GBW   = 32,
  parameter int LBW   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dram_wd_collector_if.slave bus
);

  localparam int DW = VSIZE * DBW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t         r_state;
  logic [GBW-1:0] r_addr;   // address of the current beat (base + beat*VSIZE)
  logic [LBW-1:0] r_len;
  logic [LBW-1:0] r_beat;
  logic           r_done;

  logic [DW-1:0]  r_fifo_mem [2];
  logic           r_wr_ptr;
  logic           r_rd_ptr;
  logic [1:0]     r_count;

  logic           w_full;
  logic           w_empty;
  logic           w_burst;
  logic           w_cmd_ack;
  logic           w_push;
  logic           w_pop;
  logic           w_dramw_rdy;
  logic           w_last;

  assign w_full  = (r_count == 2'd2);
  assign w_empty = (r_count == 2'd0);
  assign w_burst = (r_state == ST_BURST);

  // Acks are gated by reset so nothing is accepted while reset is held.
  // The push side only looks at the registered fill level: a full FIFO
  // refuses a beat even if the head is leaving in the same cycle.
  assign w_cmd_ack   = bus.cmd_rdy && (r_state == ST_IDLE) && !i_rst;
  assign w_push      = bus.dramwd_rdy && !w_full && !i_rst;
  assign w_dramw_rdy = w_burst && !w_empty;
  assign w_pop       = w_dramw_rdy && bus.dramw_ack;
  assign w_last      = w_burst && (r_beat == r_len - LBW'(1));

  // Burst sequencer: command acceptance, beat counting, done pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_ack) begin
            if (bus.i_cmd_len != '0) begin
              r_state <= ST_BURST;
              r_addr  <= bus.i_cmd_addr;
              r_len   <= bus.i_cmd_len;
              r_beat  <= '0;
            end else begin
              // Empty burst: complete immediately without touching DRAM
              r_done <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (w_pop) begin
            r_addr <= r_addr + GBW'(VSIZE);
            r_beat <= r_beat + LBW'(1);
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers and fill level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, the head is
  // masked onto the output only while a beat is being offered
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= bus.i_dramwd;
  end

  assign bus.cmd_ack      = w_cmd_ack;
  assign bus.dramwd_ack   = w_push;
  assign bus.dramw_rdy    = w_dramw_rdy;
  assign bus.o_dramw_addr = r_addr;
  assign bus.o_dramw_data = w_dramw_rdy ? r_fifo_mem[r_rd_ptr] : '0;
  assign bus.o_dramw_last = w_last;
  assign bus.done_dval    = r_done;
  assign bus.o_busy       = w_burst;

endmodule

// File: tb/tb_dram_wd_collector.sv
// Self-checking bench for dram_wd_collector: directed scenarios plus a
// randomized phase, all checked each cycle against a queue-based model.
module tb_dram_wd_collector;

  localparam int DBW   = 16;
  localparam int VSIZE = 32;
  localparam int GBW   = 32;
  localparam int LBW   = 8;
  localparam int DW    = VSIZE * DBW;

  logic clk = 1'b0;
  logic rst;

  dram_wd_collector_if #(.DBW(DBW), .VSIZE(VSIZE), .GBW(GBW), .LBW(LBW)) bus ();

  dram_wd_collector #(.DBW(DBW), .VSIZE(VSIZE), .GBW(GBW), .LBW(LBW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: burst descriptor plus a queue of buffered beats
  logic [DW-1:0]  m_fifo [$];
  bit             m_busy, m_done_pend, m_in_reset;
  logic [GBW-1:0] m_base;
  int             m_len, m_beat;

  // Stimulus sources
  typedef struct {
    logic [GBW-1:0] addr;
    logic [LBW-1:0] len;
  } cmd_t;
  cmd_t          cmd_q [$];
  logic [DW-1:0] src_q [$];
  int            ack_pct = 100;
  int            wd_pct  = 100;
  bit            wd_taken, cmd_taken;

  // Observations of the DUT
  int             dut_beats, dut_dones, dut_wd_acks;
  logic [GBW-1:0] dut_addrs [$];

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_obs();
    dut_beats = 0; dut_dones = 0; dut_wd_acks = 0;
    dut_addrs.delete();
  endtask

  // One clock: check at the falling edge, advance model, then drive inputs
  task automatic cycle();
    bit             e_cmd_ack, e_wd_ack, e_w_rdy, e_last, e_done;
    logic [GBW-1:0] e_addr;
    logic [DW-1:0]  e_data;
    cmd_t           c;
    @(negedge clk);
    if (m_in_reset) begin
      e_cmd_ack = 0; e_wd_ack = 0; e_w_rdy = 0; e_last = 0; e_done = 0;
      e_addr = '0; e_data = '0;
    end else begin
      e_cmd_ack = !m_busy && bus.cmd_rdy;
      e_wd_ack  = bus.dramwd_rdy && (m_fifo.size() < 2);
      e_w_rdy   = m_busy && (m_fifo.size() > 0);
      e_last    = m_busy && (m_beat == m_len - 1);
      e_done    = m_done_pend;
      e_addr    = m_base + GBW'(m_beat * VSIZE);
      e_data    = e_w_rdy ? m_fifo[0] : '0;
    end
    check_eq("ctrl{cmd_ack,wd_ack,w_rdy,last,done,busy}",
             DW'({bus.cmd_ack, bus.dramwd_ack, bus.dramw_rdy, bus.o_dramw_last, bus.done_dval, bus.o_busy}),
             DW'({e_cmd_ack, e_wd_ack, e_w_rdy, e_last, e_done, m_busy}));
    if (m_in_reset || e_w_rdy) begin
      check_eq("dramw_addr", DW'(bus.o_dramw_addr), DW'(e_addr));
      check_eq("dramw_data", bus.o_dramw_data, e_data);
    end
    if (bus.dramw_rdy && bus.dramw_ack) begin
      dut_beats++;
      dut_addrs.push_back(bus.o_dramw_addr);
    end
    if (bus.done_dval) dut_dones++;
    if (bus.dramwd_rdy && bus.dramwd_ack) dut_wd_acks++;

    cmd_taken = e_cmd_ack;
    wd_taken  = e_wd_ack;
    if (!m_in_reset) begin
      m_done_pend = 0;
      if (e_cmd_ack) begin
        if (bus.i_cmd_len == '0) m_done_pend = 1;
        else begin
          m_busy = 1; m_base = bus.i_cmd_addr; m_len = int'(bus.i_cmd_len); m_beat = 0;
        end
      end
      if (e_w_rdy && bus.dramw_ack) begin
        void'(m_fifo.pop_front());
        m_beat++;
        if (m_beat == m_len) begin m_busy = 0; m_done_pend = 1; end
      end
      if (e_wd_ack) m_fifo.push_back(bus.i_dramwd);
    end

    @(posedge clk);
    #1;
    if (wd_taken) bus.dramwd_rdy = 1'b0;
    if (!bus.dramwd_rdy && src_q.size() > 0 && int'($urandom_range(99)) < wd_pct) begin
      bus.i_dramwd   = src_q.pop_front();
      bus.dramwd_rdy = 1'b1;
    end
    if (cmd_taken) bus.cmd_rdy = 1'b0;
    if (!bus.cmd_rdy && cmd_q.size() > 0) begin
      c = cmd_q.pop_front();
      bus.i_cmd_addr = c.addr;
      bus.i_cmd_len  = c.len;
      bus.cmd_rdy    = 1'b1;
    end
    bus.dramw_ack = (int'($urandom_range(99)) < ack_pct);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  function automatic bit all_idle();
    return cmd_q.size() == 0 && !bus.cmd_rdy && src_q.size() == 0 && !bus.dramwd_rdy &&
           !m_busy && m_fifo.size() == 0 && !m_done_pend;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      cycle();
      n++;
    end
    check_eq({tag, "_finished_in_budget"}, DW'(all_idle()), DW'(1'b1));
  endtask

  // Hold reset with every request asserted, so gated acks are exercised
  task automatic do_reset(input int n);
    cmd_q.delete(); src_q.delete();
    rst = 1'b1;
    m_in_reset = 1; m_busy = 0; m_done_pend = 0; m_fifo.delete();
    m_base = '0; m_len = 0; m_beat = 0;
    bus.cmd_rdy = 1'b1; bus.i_cmd_addr = $urandom; bus.i_cmd_len = 8'd1;
    bus.dramwd_rdy = 1'b1; bus.i_dramwd = rnd_beat(); bus.dramw_ack = 1'b1;
    run(n);
    bus.cmd_rdy = 1'b0; bus.dramwd_rdy = 1'b0;
    rst = 1'b0;
    m_in_reset = 0;
  endtask

  task automatic add_burst(input logic [GBW-1:0] addr, input int len);
    cmd_t c;
    c.addr = addr;
    c.len  = LBW'(len);
    cmd_q.push_back(c);
    for (int i = 0; i < len; i++) src_q.push_back(rnd_beat());
  endtask

  initial begin
    int base_beats;
    int guard;
    do_reset(3);

    // Streaming burst with DRAM always ready
    clear_obs(); ack_pct = 100; wd_pct = 100;
    add_burst(32'h0000_0100, 4);
    wait_idle("stream", 50);
    check_eq("stream_beats", DW'(dut_beats), DW'(4));
    check_eq("stream_dones", DW'(dut_dones), DW'(1));
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("stream_addr%0d", i),
               DW'(dut_addrs.size() > i ? dut_addrs[i] : 32'hDEAD_BEEF), DW'(32'h100 + 32'h20 * i));

    // Prefetch before the command: two beats buffered, third held off
    clear_obs();
    for (int i = 0; i < 3; i++) src_q.push_back(rnd_beat());
    run(6);
    check_eq("prefetch_wd_acks", DW'(dut_wd_acks), DW'(2));
    check_eq("prefetch_no_beats", DW'(dut_beats), DW'(0));
    cmd_q.push_back('{addr: 32'h0000_3000, len: 8'd3});
    wait_idle("prefetch", 50);
    check_eq("prefetch_beats", DW'(dut_beats), DW'(3));
    check_eq("prefetch_dones", DW'(dut_dones), DW'(1));

    // DRAM stall mid-burst
    clear_obs();
    add_burst(32'h0000_2000, 4);
    run(3);
    ack_pct = 0; bus.dramw_ack = 1'b0;
    base_beats = dut_beats;
    run(5);
    check_eq("stall_no_beats", DW'(dut_beats - base_beats), DW'(0));
    check_eq("stall_w_rdy_held", DW'(bus.dramw_rdy), DW'(1'b1));
    check_eq("stall_wd_ack_low", DW'(bus.dramwd_ack), DW'(1'b0));
    ack_pct = 100;
    wait_idle("stall", 50);
    check_eq("stall_beats", DW'(dut_beats), DW'(4));

    // Address wrap past 2^GBW
    clear_obs();
    add_burst(32'hFFFF_FFF0, 2);
    wait_idle("wrap", 50);
    check_eq("wrap_addr0", DW'(dut_addrs.size() > 0 ? dut_addrs[0] : 32'hDEAD_BEEF), DW'(32'hFFFF_FFF0));
    check_eq("wrap_addr1", DW'(dut_addrs.size() > 1 ? dut_addrs[1] : 32'hDEAD_BEEF), DW'(32'h0000_0010));

    // Zero-length command
    clear_obs();
    add_burst(32'h0000_0400, 0);
    wait_idle("len0", 20);
    check_eq("len0_beats", DW'(dut_beats), DW'(0));
    check_eq("len0_dones", DW'(dut_dones), DW'(1));

    // Reset in the middle of a long burst
    clear_obs();
    add_burst(32'h0000_4000, 8);
    guard = 0;
    while (m_beat < 2 && guard < 50) begin
      cycle();
      guard++;
    end
    check_eq("midreset_reached_beat2", DW'(m_beat), DW'(2));
    do_reset(2);
    clear_obs();
    run(4);
    check_eq("postreset_no_beats", DW'(dut_beats), DW'(0));
    check_eq("postreset_no_dones", DW'(dut_dones), DW'(0));
    add_burst(32'h0000_0500, 1);
    wait_idle("postreset", 30);
    check_eq("postreset_beats", DW'(dut_beats), DW'(1));
    check_eq("postreset_dones", DW'(dut_dones), DW'(1));
    check_eq("postreset_addr", DW'(dut_addrs.size() > 0 ? dut_addrs[0] : 32'hDEAD_BEEF), DW'(32'h500));

    // Randomized traffic with random back-pressure on both data sides
    for (int g = 0; g < 4; g++) begin
      int exp_beats, exp_cmds;
      clear_obs();
      exp_beats = 0; exp_cmds = 0;
      ack_pct = int'($urandom_range(30, 100));
      wd_pct  = int'($urandom_range(30, 100));
      for (int k = 0; k < 10; k++) begin
        int len;
        logic [GBW-1:0] a;
        len = int'($urandom_range(0, 6));
        a = ($urandom_range(3) == 0) ? 32'hFFFF_FF00 + GBW'($urandom_range(255)) : GBW'($urandom);
        add_burst(a, len);
        exp_beats += len;
        exp_cmds++;
      end
      wait_idle($sformatf("rand%0d", g), 2000);
      check_eq($sformatf("rand%0d_beats", g), DW'(dut_beats), DW'(exp_beats));
      check_eq($sformatf("rand%0d_dones", g), DW'(dut_dones), DW'(exp_cmds));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram_wd_collector.md
DRAM_WD_COLLECTOR -- requirements
Module: dram_wd_collector

Interface
REQ-001 SHALL have parameter DBW, default 16, DRAM word width in bits.
REQ-002 SHALL have parameter VSIZE, default 32, words per vector beat.
REQ-003 SHALL have parameter GBW, default 32, DRAM word-address width.
REQ-004 SHALL have parameter LBW, default 8, burst-length field width.
REQ-005 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port cmd_rdy  in  1  write-command valid.
REQ-008 SHALL have port cmd_ack  out  1  write-command accepted.
REQ-009 SHALL have port i_cmd_addr  in  GBW  burst base word address.
REQ-010 SHALL have port i_cmd_len  in  LBW  beats in burst.
REQ-011 SHALL have port dramwd_rdy  in  1  ALU write-data beat valid.
REQ-012 SHALL have port dramwd_ack  out  1  ALU write-data beat accepted.
REQ-013 SHALL have port i_dramwd  in  VSIZE x DBW  write-data beat.
REQ-014 SHALL have port dramw_rdy  out  1  DRAM write beat valid.
REQ-015 SHALL have port dramw_ack  in  1  DRAM write beat accepted.
REQ-016 SHALL have port o_dramw_addr  out  GBW  beat word address.
REQ-017 SHALL have port o_dramw_data  out  VSIZE x DBW  beat data.
REQ-018 SHALL have port o_dramw_last  out  1  final beat of burst.
REQ-019 SHALL have port done_dval  out  1  one-cycle pulse, burst complete.
REQ-020 SHALL have port o_busy  out  1  high while in BURST.

Function
REQ-021 SHALL treat every rdy/ack pair as: transfer iff rdy && ack in same cycle; sender holds rdy and data stable until ack; ack never asserted without rdy.
REQ-022 SHALL buffer incoming beats in a 2-entry registered FIFO, in order, independent of state (prefetch allowed in IDLE).
REQ-023 SHALL drive dramwd_ack = dramwd_rdy && FIFO not full; no combinational path from dramw_ack to dramwd_ack (push blocked when full, even with simultaneous pop).
REQ-024 SHALL implement states IDLE and BURST.
REQ-025 SHALL in IDLE drive cmd_ack = cmd_rdy; on acceptance with i_cmd_len != 0, latch base and len, clear beat counter, enter BURST next cycle.
REQ-026 SHALL on acceptance of i_cmd_len == 0 stay IDLE, issue no beat, pulse done_dval next cycle.
REQ-027 SHALL hold cmd_ack low in BURST.
REQ-028 SHALL drive dramw_rdy = BURST && FIFO not empty; o_dramw_data = FIFO head.
REQ-029 SHALL drive o_dramw_addr = base + beat*VSIZE, modulo 2^GBW (wrap silently).
REQ-030 SHALL drive o_dramw_last = (beat == len-1) during BURST.
REQ-031 SHALL on dramw_ack pop FIFO and increment beat; if last, return to IDLE and pulse done_dval the following cycle.
REQ-032 SHALL have minimum latency: beat pushed into empty FIFO in cycle t visible on dramw_rdy in cycle t+1 when in BURST.
REQ-033 SHALL sustain one beat per cycle when both sides stream without stall.
REQ-034 SHALL drive o_busy = (state == BURST).

Reset
REQ-035 SHALL on i_rst (any time, asynchronous) force IDLE, empty FIFO, beat = 0, base/len = 0.
REQ-036 SHALL hold during/after reset: cmd_ack = 0, dramwd_ack = 0, dramw_rdy = 0, o_dramw_last = 0, done_dval = 0, o_busy = 0, o_dramw_addr = 0, o_dramw_data = 0.
REQ-037 SHALL abandon a partial burst on reset mid-operation; no beat or done_dval after deassertion until a new command.

Verification
REQ-038 SHALL cover: cmd addr=0x100 len=4, 4 beats back-to-back, dramw_ack tied 1 -> addrs 0x100,0x120,0x140,0x160, last on 4th, done_dval one cycle after.
REQ-039 SHALL cover: 3 beats offered before any cmd -> first 2 acked, 3rd stalled; cmd len=3 -> all 3 emitted in order.
REQ-040 SHALL cover: dramw_ack held 0 for 5 cycles mid-burst -> dramw_rdy, addr, data stable; dramwd_ack 0 once 2 beats buffered.
REQ-041 SHALL cover: cmd addr=0xFFFFFFF0 len=2 -> addrs 0xFFFFFFF0, 0x00000010.
REQ-042 SHALL cover: cmd len=0 -> cmd_ack, no dramw_rdy, done_dval pulse, stays IDLE.
REQ-043 SHALL cover: i_rst asserted after beat 2 of len=8 -> all outputs 0 immediately; new cmd len=1 afterward completes normally.
